matrix_scan_ctrl: RTL

Sequencer that walks a full matrix element by element, reading each element from the source matrix space and writing it to the destination space, optionally transposed. It drives the 18-bit matrix data address (9-bit row half, 9-bit column half, row half in bits 17:9) with a req/ack memory handshake. It sits between the microcode control unit and data memory and replaces per-element microcode loops for bulk copy and transpose instructions.

---
 rtl/matrix_scan_ctrl_pkg.sv | 18 +
 rtl/matrix_scan_ctrl_scan_counter2d.sv | 70 +++++++
 rtl/matrix_scan_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/matrix_scan_ctrl_pkg.sv
// Shared types and constants for the matrix scan sequencer.
// Address layout: row half in the upper HALF_W bits, column half in the lower.
package matrix_scan_ctrl_pkg;

   localparam int HALF_W_DEF = 9;
   localparam int DATA_W_DEF = 8;

   localparam logic BANK_SRC = 1'b0;
   localparam logic BANK_DST = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      DONE = 2'd3
   } scan_state_t;

endpackage : matrix_scan_ctrl_pkg

// File: rtl/matrix_scan_ctrl_scan_counter2d.sv
// Row/column element counter for the matrix scan.
// The limits are latched on load and never change while the scan runs.
module scan_counter2d
   import matrix_scan_ctrl_pkg::*;
#(
   parameter int HALF_W = HALF_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              advance,
   input  logic [HALF_W-1:0] rows_m1,
   input  logic [HALF_W-1:0] cols_m1,
   output logic [HALF_W-1:0] row,
   output logic [HALF_W-1:0] col,
   output logic              last
);

   localparam logic [HALF_W-1:0] HALF_ONE = {{(HALF_W-1){1'b0}}, 1'b1};

   logic [HALF_W-1:0] row_reg, row_next;
   logic [HALF_W-1:0] col_reg, col_next;
   logic [HALF_W-1:0] rows_lim_reg, rows_lim_next;
   logic [HALF_W-1:0] cols_lim_reg, cols_lim_next;
   logic              col_at_end;
   logic              row_at_end;

   assign col_at_end = (col_reg == cols_lim_reg);
   assign row_at_end = (row_reg == rows_lim_reg);

   // Advancing past the final element is suppressed so no counter can exceed its limit.
   always_comb begin
      row_next      = row_reg;
      col_next      = col_reg;
      rows_lim_next = rows_lim_reg;
      cols_lim_next = cols_lim_reg;
      if (load) begin
         row_next      = '0;
         col_next      = '0;
         rows_lim_next = rows_m1;
         cols_lim_next = cols_m1;
      end else if (advance && !(row_at_end && col_at_end)) begin
         if (col_at_end) begin
            col_next = '0;
            row_next = row_reg + HALF_ONE;
         end else begin
            col_next = col_reg + HALF_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         row_reg      <= '0;
         col_reg      <= '0;
         rows_lim_reg <= '0;
         cols_lim_reg <= '0;
      end else begin
         row_reg      <= row_next;
         col_reg      <= col_next;
         rows_lim_reg <= rows_lim_next;
         cols_lim_reg <= cols_lim_next;
      end
   end

   assign row  = row_reg;
   assign col  = col_reg;
   assign last = row_at_end && col_at_end;

endmodule : scan_counter2d

// File: rtl/matrix_scan_ctrl.sv
// Element-by-element matrix copy/transpose sequencer with a req/ack memory port.
// Each element is read from the source bank, held, then written to the destination bank.
module matrix_scan_ctrl
   import matrix_scan_ctrl_pkg::*;
#(
   parameter int HALF_W = HALF_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                abort,
   input  logic [HALF_W-1:0]   rows_m1,
   input  logic [HALF_W-1:0]   cols_m1,
   input  logic                transpose,
   output logic                mem_req,
   output logic                mem_we,
   output logic                mem_bank,
   output logic [2*HALF_W-1:0] mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                mem_ack,
   output logic                busy,
   output logic                done
);

   scan_state_t       state_reg, state_next;
   logic [DATA_W-1:0] hold_reg, hold_next;
   logic              transpose_reg, transpose_next;

   logic [HALF_W-1:0] row;
   logic [HALF_W-1:0] col;
   logic              last;
   logic              load_cnt;
   logic              adv_cnt;
   logic [HALF_W-1:0] wr_row_half;
   logic [HALF_W-1:0] wr_col_half;

   assign load_cnt = (state_reg == IDLE) && start;
   // An aborted write is never counted as completed, even if acked in the same cycle.
   assign adv_cnt  = (state_reg == WR) && mem_ack && !abort;

   scan_counter2d #(
      .HALF_W (HALF_W)
   ) u_counter (
      .clk     (clk),
      .reset   (reset),
      .load    (load_cnt),
      .advance (adv_cnt),
      .rows_m1 (rows_m1),
      .cols_m1 (cols_m1),
      .row     (row),
      .col     (col),
      .last    (last)
   );

   genvar gi;
   generate
      for (gi = 0; gi < HALF_W; gi++) begin : g_wr_addr
         assign wr_row_half[gi] = transpose_reg ? col[gi] : row[gi];
         assign wr_col_half[gi] = transpose_reg ? row[gi] : col[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = RD;
            end
         end
         RD: begin
            if (abort) begin
               state_next = IDLE;
            end else if (mem_ack) begin
               state_next = WR;
            end
         end
         WR: begin
            if (abort) begin
               state_next = IDLE;
            end else if (mem_ack) begin
               state_next = last ? DONE : RD;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_comb begin
      hold_next      = hold_reg;
      transpose_next = transpose_reg;
      if ((state_reg == RD) && mem_ack && !abort) begin
         hold_next = mem_rdata;
      end
      if (load_cnt) begin
         transpose_next = transpose;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hold_reg      <= '0;
         transpose_reg <= 1'b0;
      end else begin
         hold_reg      <= hold_next;
         transpose_reg <= transpose_next;
      end
   end

   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_bank  = BANK_SRC;
      mem_addr  = '0;
      mem_wdata = '0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state_reg)
         RD: begin
            mem_req  = 1'b1;
            mem_bank = BANK_SRC;
            mem_addr = {row, col};
            busy     = 1'b1;
         end
         WR: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_bank  = BANK_DST;
            mem_addr  = {wr_row_half, wr_col_half};
            mem_wdata = hold_reg;
            busy      = 1'b1;
         end
         DONE: begin
            done = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule : matrix_scan_ctrl
